// File: rtl/transmitter.sv
// UART message transmitter.
//
// Sends a fixed message of MSG_LEN bytes ("UART" by default) as back-to-back
// UART frames whenever start shows a rising edge while the block is idle.
// Default frame is 8N1; defining TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1).
//
// Parameters:
//   CLK_FREQ  input clock frequency in Hz
//   BAUD      serial bit rate in bit/s
//   MSG_LEN   number of bytes sent per message
//
// Ports:
//   clk    rising-edge clock for all logic
//   rst    synchronous, active-high reset
//   start  message request; only a rising edge starts a transmission
//   tx     registered serial line, idle high
//
// Optional feature macro: TX_PARITY_EN

module transmitter #(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned BAUD     = 115200,
   parameter int unsigned MSG_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic tx
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStartBit,
      StData,
`ifdef TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [IDX_W-1:0] idx;
   logic             start_d;
   logic [7:0]       cur_byte;
   logic             trigger;
   logic             bit_end;

   assign trigger = start & ~start_d;
   assign bit_end = (baud_cnt == CNT_MAX);

   // Message ROM; positions beyond the built-in text read as zero.
   always_comb begin
      cur_byte = 8'h00;
      case (32'(idx))
         0: cur_byte = 8'h55;
         1: cur_byte = 8'h41;
         2: cur_byte = 8'h52;
         3: cur_byte = 8'h54;
         default: cur_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         idx      <= '0;
         start_d  <= 1'b0;
      end else begin
         start_d <= start;

         // Baud counter restarts at every bit boundary; held at zero in idle.
         if (state != StIdle) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
         end

         case (state)
            StIdle: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               idx      <= '0;
               if (trigger) begin
                  state <= StStartBit;
                  tx    <= 1'b0;
               end
            end

            StStartBit: begin
               if (bit_end) begin
                  state <= StData;
                  tx    <= cur_byte[0];
               end
            end

            StData: begin
               if (bit_end) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef TX_PARITY_EN
                     state   <= StParity;
                     tx      <= ^cur_byte;
`else
                     state   <= StStop;
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= cur_byte[bit_cnt + 3'd1];
                  end
               end
            end

`ifdef TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  state <= StStop;
                  tx    <= 1'b1;
               end
            end
`endif

            StStop: begin
               if (bit_end) begin
                  if (idx == IDX_LAST) begin
                     // Any trigger on this edge is dropped: we are not yet idle.
                     state <= StIdle;
                     tx    <= 1'b1;
                     idx   <= '0;
                  end else begin
                     // Next frame follows with no idle gap.
                     state <= StStartBit;
                     tx    <= 1'b0;
                     idx   <= idx + IDX_W'(1);
                  end
               end
            end

            default: begin
               state <= StIdle;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter (default 8N1 build) at 8 clocks per bit.
// A reference model watches rst/start on each clock edge; on an accepted
// trigger it pushes the full expected tx waveform of the message into a queue,
// and every cycle the DUT's tx is compared against the popped value (or idle
// high when the queue is empty).

module tb_transmitter;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned BAUD     = 125000;
   localparam int unsigned MSG_LEN  = 4;
   localparam int unsigned CPB      = CLK_FREQ / BAUD;
   localparam int unsigned MSG_CYC  = MSG_LEN * 10 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic tx;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_msg = 0;
   int   cycle = 0;
   logic model_sd = 1'b0;
   logic exp_tx = 1'b1;
   logic exp_q[$];
   logic [7:0] msg_bytes [MSG_LEN] = '{8'h55, 8'h41, 8'h52, 8'h54};

   transmitter #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD),
      .MSG_LEN (MSG_LEN)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, obs, exp);
      end
   endtask

   // Expected line waveform for one whole message, plus the trailing cycle in
   // which the transmitter is still finishing its last stop bit edge.
   task automatic push_message();
      for (int b = 0; b < int'(MSG_LEN); b++) begin
         for (int c = 0; c < int'(CPB); c++) exp_q.push_back(1'b0);
         for (int i = 0; i < 8; i++)
            for (int c = 0; c < int'(CPB); c++) exp_q.push_back(msg_bytes[b][i]);
         for (int c = 0; c < int'(CPB); c++) exp_q.push_back(1'b1);
      end
      exp_q.push_back(1'b1);
      n_msg++;
   endtask

   // Reference model and per-cycle comparison.
   always begin
      @(posedge clk);
      cycle++;
      if (rst) begin
         exp_q.delete();
         model_sd = 1'b0;
         exp_tx   = 1'b1;
      end else begin
         if (exp_q.size() == 0 && start && !model_sd) push_message();
         model_sd = start;
         exp_tx   = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      end
      #1;
      check("tx_cycle", 32'(tx), 32'(exp_tx));
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   int msg0;

   initial begin
      // Reset held for 5 cycles, then idle with start low.
      wait_cyc(5);
      check("reset_tx", 32'(tx), 32'd1);
      rst = 1'b0;
      wait_cyc(20);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_no_msg", 32'(n_msg), 32'd0);

      // Single pulse: one full message.
      pulse();
      @(negedge clk);
      check("start_bit_latency", 32'(tx), 32'd0);
      wait_cyc(MSG_CYC + 20);
      check("one_msg", 32'(n_msg), 32'd1);

      // Held start: only one message.
      msg0 = n_msg;
      @(negedge clk) start = 1'b1;
      wait_cyc(10000);
      start = 1'b0;
      wait_cyc(MSG_CYC);
      check("held_start_one_msg", 32'(n_msg - msg0), 32'd1);

      // Pulse during transmission ignored; pulse after idle resends.
      msg0 = n_msg;
      pulse();
      wait_cyc(100);
      pulse();
      wait_cyc(MSG_CYC);
      check("busy_pulse_ignored", 32'(n_msg - msg0), 32'd1);
      pulse();
      wait_cyc(MSG_CYC + 10);
      check("resend_after_idle", 32'(n_msg - msg0), 32'd2);

      // Reset during byte 2 data bits aborts; next message starts at 0x55.
      pulse();
      wait_cyc(2 * 10 * CPB + 3 * CPB);
      rst = 1'b1;
      @(negedge clk);
      check("abort_tx_high", 32'(tx), 32'd1);
      rst = 1'b0;
      wait_cyc(30);
      check("abort_stays_idle", 32'(tx), 32'd1);
      msg0 = n_msg;
      pulse();
      wait_cyc(MSG_CYC + 10);
      check("after_abort_msg", 32'(n_msg - msg0), 32'd1);

      // start already high when reset releases counts as an edge.
      msg0 = n_msg;
      @(negedge clk) begin rst = 1'b1; start = 1'b1; end
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(MSG_CYC + 10);
      start = 1'b0;
      wait_cyc(5);
      check("start_high_at_release", 32'(n_msg - msg0), 32'd1);

      // Trigger coinciding with the final stop-to-idle edge is dropped.
      msg0 = n_msg;
      pulse();
      wait_cyc(MSG_CYC - 1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_cyc(MSG_CYC + 10);
      check("final_edge_trigger_ignored", 32'(n_msg - msg0), 32'd1);
      check("end_idle", 32'(tx), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
